// File: rtl/mem_access_stage.sv
// s2 memory access stage: req/gnt/rvalid data port, load align/extend.
// Optional misaligned trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic [1:0]  mem_op,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_busy,
  output logic [31:0] load_data_s3,
  output logic        load_valid_s3,
  output logic        bus_error,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [29:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d;
  logic        lv_q, lv_d;
  logic        berr_q, berr_d;

  logic        is_acc;
  logic        issue;
  logic [1:0]  off_a;
  logic [3:0]  be_a;
  logic [31:0] wd_a;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [CNT_W-1:0] cnt_inc;

  assign is_acc  = (mem_op == 2'b01) || (mem_op == 2'b10);
  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic mis;
  logic mis_q, mis_d;

  // Misalignment detect on the incoming s2 op
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (mem_size == 2'b00): mis = 1'b0;
      (mem_size == 2'b01): mis = addr[0];
      default:             mis = (addr[1:0] != 2'b00);
    endcase
  end

  assign issue      = is_acc && !mis;
  assign mis_d      = is_acc && mis && (state_q == S_IDLE);
  assign misaligned = mis_q;

  // Trap pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          mis_q <= 1'b0;
    else if (clk_enable) mis_q <= mis_d;
  end
`else
  assign issue      = is_acc;
  assign misaligned = 1'b0;
`endif

  // Aligned-down lane offset, enables and replicated write data
  always_comb begin
    off_a = 2'b00;
    be_a  = 4'b1111;
    wd_a  = store_data;
    unique case (1'b1)
      (mem_size == 2'b00): begin
        off_a = addr[1:0];
        be_a  = 4'b0001 << addr[1:0];
        wd_a  = {4{store_data[7:0]}};
      end
      (mem_size == 2'b01): begin
        off_a = {addr[1], 1'b0};
        be_a  = 4'b0011 << {addr[1], 1'b0};
        wd_a  = {2{store_data[15:0]}};
      end
      default: begin
        off_a = 2'b00;
        be_a  = 4'b1111;
        wd_a  = store_data;
      end
    endcase
  end

  assign shifted = dmem_rdata >> {off_q, 3'b000};

  // Load extraction and extension
  always_comb begin
    ext = shifted;
    unique case (1'b1)
      (size_q == 2'b00):
        ext = uns_q ? {24'b0, shifted[7:0]}
                    : {{24{shifted[7]}}, shifted[7:0]};
      (size_q == 2'b01):
        ext = uns_q ? {16'b0, shifted[15:0]}
                    : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = (mem_op == 2'b10);
          waddr_d = addr[31:2];
          be_d    = be_a;
          wdata_d = wd_a;
          size_d  = mem_size;
          uns_d   = mem_unsigned;
          off_d   = off_a;
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = S_IDLE;
          end else if (dmem_rvalid) begin
            state_d = S_IDLE;
            ld_d    = ext;
            lv_d    = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          state_d = S_IDLE;
          ld_d    = ext;
          lv_d    = 1'b1;
        end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
          state_d = S_IDLE;
          ld_d    = '0;
          berr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, frozen while clk_enable is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      lv_q    <= 1'b0;
      berr_q  <= 1'b0;
    end else if (clk_enable) begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      berr_q  <= berr_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = waddr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign mem_busy      = (state_q != S_IDLE);
  assign load_data_s3  = ld_q;
  assign load_valid_s3 = lv_q;
  assign bus_error     = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed steps plus randomized accesses.
// Build with MEM_ACCESS_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_mem_access_stage;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_enable = 1'b1;
  logic [1:0]  mem_op = 2'b00;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_busy;
  logic [31:0] load_data_s3;
  logic        load_valid_s3;
  logic        bus_error;
  logic        misaligned;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_ld = '0;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(MAXW), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .mem_op(mem_op), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr),
    .store_data(store_data), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_busy(mem_busy),
    .load_data_s3(load_data_s3),
    .load_valid_s3(load_valid_s3),
    .bus_error(bus_error), .misaligned(misaligned)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_ea(input logic [31:0] a,
                                       input logic [1:0] sz);
    int n = nbytes(sz);
    return a - (a % n);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a,
                                      input logic [1:0] sz);
    int n = nbytes(sz);
    int lane = int'(m_ea(a, sz) % 4);
    logic [3:0] be = '0;
    for (int i = 0; i < n; i++) be[lane+i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] sd,
                                       input logic [1:0] sz);
    int n = nbytes(sz);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = sd[8*(j % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] rd,
                                       input logic [31:0] a,
                                       input logic [1:0] sz,
                                       input logic uns);
    int n = nbytes(sz);
    int lane = int'(m_ea(a, sz) % 4);
    logic [31:0] v = '0;
    logic [31:0] hi;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(lane+i) +: 8];
    if (n < 4 && !uns && v[8*n-1]) begin
      hi = 32'hFFFF_FFFF << (8 * n);
      v = v | hi;
    end
    return v;
  endfunction

  task automatic access(input logic [1:0] op, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int gd, input int rdly);
    logic [31:0] ea = m_ea(a, sz);
    logic [31:0] eld = m_ld(rd, a, sz, uns);
    logic st = (op == 2'b10);
    mem_op = op; mem_size = sz; mem_unsigned = uns;
    addr = a; store_data = sd;
    @(negedge clk);
    mem_op = 2'b00; addr = $urandom; store_data = $urandom;
    check("req_up", {31'b0, dmem_req}, 32'd1);
    check("we", {31'b0, dmem_we}, {31'b0, st});
    check("waddr", {2'b0, dmem_addr}, {2'b0, ea[31:2]});
    check("be", {28'b0, dmem_be}, {28'b0, m_be(a, sz)});
    if (st) check("wdata", dmem_wdata, m_wd(sd, sz));
    check("busy_req", {31'b0, mem_busy}, 32'd1);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      check("req_hold", {31'b0, dmem_req}, 32'd1);
      check("addr_hold", {2'b0, dmem_addr}, {2'b0, ea[31:2]});
    end
    dmem_gnt = 1'b1;
    if (!st && rdly == 0) begin
      dmem_rvalid = 1'b1; dmem_rdata = rd;
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    check("req_drop", {31'b0, dmem_req}, 32'd0);
    if (st) begin
      check("busy_st", {31'b0, mem_busy}, 32'd0);
    end else begin
      if (rdly > 0) begin
        check("busy_wait", {31'b0, mem_busy}, 32'd1);
        for (int i = 1; i < rdly; i++) begin
          @(negedge clk);
          check("lv_early", {31'b0, load_valid_s3}, 32'd0);
        end
        dmem_rvalid = 1'b1; dmem_rdata = rd;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end
      check("lv_pulse", {31'b0, load_valid_s3}, 32'd1);
      check("ld_data", load_data_s3, eld);
      check("busy_ld", {31'b0, mem_busy}, 32'd0);
      last_ld = eld;
      @(negedge clk);
      check("lv_once", {31'b0, load_valid_s3}, 32'd0);
      check("ld_hold", load_data_s3, eld);
    end
  endtask

  initial begin
    #3;
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_busy", {31'b0, mem_busy}, 32'd0);
    check("rst_be", {28'b0, dmem_be}, 32'd0);
    check("rst_ld", load_data_s3, 32'd0);
    check("rst_flags", {29'b0, load_valid_s3, bus_error, misaligned},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_noop", {31'b0, dmem_req}, 32'd0);
    mem_op = 2'b11; addr = 32'h10;
    @(negedge clk);
    check("op11_noreq", {31'b0, dmem_req}, 32'd0);
    check("op11_idle", {31'b0, mem_busy}, 32'd0);
    mem_op = 2'b00;

    access(2'b10, 2'b00, 1'b0, 32'h1003, 32'h0000_00A5, '0, 0, 0);
    access(2'b01, 2'b01, 1'b0, 32'h2002, '0, 32'h8001_1234, 0, 3);
    check("tp_half", last_ld, 32'hFFFF_8001);
    access(2'b01, 2'b00, 1'b1, 32'h2001, '0, 32'h0000_F000, 0, 0);
    check("tp_byte", last_ld, 32'h0000_00F0);

    mem_op = 2'b01; mem_size = 2'b10; addr = 32'h5000;
    @(negedge clk);
    mem_op = 2'b00; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    for (int i = 1; i < MAXW; i++) begin
      @(negedge clk);
      check("to_busy", {31'b0, mem_busy}, 32'd1);
      check("to_noerr", {31'b0, bus_error}, 32'd0);
    end
    @(negedge clk);
    check("to_err", {31'b0, bus_error}, 32'd1);
    check("to_data", load_data_s3, 32'd0);
    check("to_idle", {31'b0, mem_busy}, 32'd0);
    last_ld = '0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_lv", {31'b0, load_valid_s3}, 32'd0);
    check("late_err", {31'b0, bus_error}, 32'd0);
    check("late_data", load_data_s3, 32'd0);

    mem_op = 2'b01; mem_size = 2'b10; addr = 32'h4000;
    @(negedge clk);
    mem_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      clk_enable = (i % 2 == 0);
      dmem_gnt = (i % 2 == 1);
      @(negedge clk);
      check("stall_req", {31'b0, dmem_req}, 32'd1);
      check("stall_addr", {2'b0, dmem_addr}, 32'h1000);
      check("stall_be", {28'b0, dmem_be}, 32'hF);
      check("stall_busy", {31'b0, mem_busy}, 32'd1);
    end
    clk_enable = 1'b1; dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, dmem_req}, 32'd0);
    check("arst_busy", {31'b0, mem_busy}, 32'd0);
    last_ld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("arst_lv", {31'b0, load_valid_s3}, 32'd0);
    check("arst_ld", load_data_s3, 32'd0);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    access(2'b01, 2'b10, 1'b0, 32'h6000, '0, 32'hCAFE_F00D, 0, 1);
    mem_op = 2'b10; mem_size = 2'b10; addr = 32'h3002;
    @(negedge clk);
    mem_op = 2'b00;
    check("mis_pulse", {31'b0, misaligned}, 32'd1);
    check("mis_noreq", {31'b0, dmem_req}, 32'd0);
    check("mis_idle", {31'b0, mem_busy}, 32'd0);
    @(negedge clk);
    check("mis_once", {31'b0, misaligned}, 32'd0);
    mem_op = 2'b01; mem_size = 2'b01; addr = 32'h3001;
    @(negedge clk);
    mem_op = 2'b00;
    check("misl_pulse", {31'b0, misaligned}, 32'd1);
    check("misl_lv", {31'b0, load_valid_s3}, 32'd0);
    check("misl_ld", load_data_s3, last_ld);
    check("misl_noreq", {31'b0, dmem_req}, 32'd0);
    @(negedge clk);
`else
    mem_op = 2'b10; mem_size = 2'b10; addr = 32'h3002;
    store_data = 32'h0BAD_CAFE;
    @(negedge clk);
    mem_op = 2'b00;
    check("al_req", {31'b0, dmem_req}, 32'd1);
    check("al_addr", {2'b0, dmem_addr}, 32'h0C00);
    check("al_be", {28'b0, dmem_be}, 32'hF);
    check("al_wd", dmem_wdata, 32'h0BAD_CAFE);
    check("al_nomis", {31'b0, misaligned}, 32'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("al_done", {31'b0, mem_busy}, 32'd0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [1:0] op, sz;
      logic [31:0] a;
      op = 2'($urandom_range(1, 2));
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      a = m_ea(a, sz);
`endif
      access(op, sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
